sa_load_sequencer: RTL
======================

Name: sa_load_sequencer

Overview:
- Parametrised successor to the fixed weight-preload / feature-load pair that shares one single-port RAM.
- A single FSM owns the RAM read port: it fetches TAPS weights into a held register bank, then streams ROWS rows of LANES features.
- Features are emitted skewed per lane, ready to feed the systolic array.
- Read-data routing uses an internal one-cycle-delayed phase/index tag, not an external mode mux.

Parameters:
DATA_W, 8, RAM word / operand width
ADDR_W, 6, RAM address width
TAPS, 9, weights per preload (≥1)
LANES, 3, feature lanes into the array (≥1)
ROWS, 2, feature rows per job (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start_i  in  1  job request, sampled only in IDLE
mode_i  in  1  0=weights then features, 1=features only (reuse held weights)
weight_base_i  in  ADDR_W  first weight address, latched on accepted start
feature_base_i  in  ADDR_W  first feature address, latched on accepted start
ram_addr_o  out  ADDR_W  RAM read address
ram_rd_o  out  1  read issued this cycle
ram_q_i  in  DATA_W  RAM data, valid the cycle after ram_rd_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse at job end
weights_o  out  TAPS*DATA_W  weight bank; tap k occupies bits [k*DATA_W +: DATA_W]
weights_valid_o  out  1  bank fully loaded
feat_o  out  LANES*DATA_W  skewed lane data
feat_valid_o  out  LANES  per-lane valid
sa_en_o  out  1  OR of feat_valid_o

Behaviour:
- Reset (rst=0 at a clk edge): FSM→IDLE. All outputs 0, including weights_o, weights_valid_o and the skew pipe. A mid-job reset aborts with no done_o.
- States: IDLE, W_FETCH, W_DRAIN, F_FETCH, F_DRAIN, FLUSH, DONE.
- IDLE: on start_i=1, latch the bases and go to W_FETCH.
  - Exception: mode_i=1 and weights_valid_o=1 → go straight to F_FETCH.
  - mode_i=1 with weights_valid_o=0 is forced to full mode.
  - start_i in any other state is ignored.
- W_FETCH:
  - On entry, weights_valid_o←0.
  - One read per cycle, addr = weight_base+k for k=0..TAPS-1; addresses wrap mod 2^ADDR_W.
  - Data returned the next cycle is written to tap k using the delayed index tag.
  - After the last issue, go to W_DRAIN for one cycle, which captures the last tap. weights_valid_o←1 at the end of W_DRAIN.
- F_FETCH:
  - One read per cycle, addr = feature_base + r*LANES + l (mod 2^ADDR_W), lanes inner, rows outer, no bubbles.
  - Returned data goes to a staging row.
  - When lane LANES-1 of a row is captured, the row is loaded into the skew pipe: lane l is presented with feat_valid_o[l]=1 exactly l+1 cycles after that capture, for one cycle each.
  - Rows arrive LANES cycles apart, so there is no pipe overlap hazard.
- F_DRAIN: one cycle, captures the final lane. Then FLUSH for LANES cycles until lane LANES-1 of the last row is out, then DONE.
- DONE: done_o=1 for one cycle, then IDLE. The weight bank holds its value until the next W_FETCH or reset.
- Latency, with start accepted at cycle 0:
  - Full mode: done_o at cycle TAPS+ROWS*LANES+LANES+3.
  - Features-only: done_o at cycle ROWS*LANES+LANES+2.
- ram_rd_o is low in IDLE, W_DRAIN, F_DRAIN, FLUSH and DONE. ram_addr_o is don't-care when ram_rd_o=0 but is held at its last value.

Decomposition:
- Shared package sa_pkg holds:
  - state enum (IDLE..DONE);
  - localparams TAP_IDX_W=$clog2(TAPS), FEAT_CNT_W=$clog2(ROWS*LANES).
- One natural sub-module: sa_lane_skew, a LANES-deep triangular delay of data+valid, parametrised by DATA_W and LANES.

Test Plan:
- Full mode, defaults, RAM[i]=i, weight_base=0, feature_base=16, start at cycle 0:
  - ram_addr_o runs 0..8 then 16..21.
  - weights_o taps = 0..8.
  - feat lanes give rows (16,17,18),(19,20,21), lane l valid l cycles after lane 0.
  - done_o at cycle 21.
- Features-only after the previous job, feature_base=30:
  - No weight reads; weights_o unchanged.
  - Rows (30,31,32),(33,34,35).
  - done_o at cycle 11.
- Wrap: weight_base=60:
  - Addresses 60,61,62,63,0,1,2,3,4.
  - Taps hold RAM contents of those addresses in order.
- mode_i=1 right after reset (weights_valid_o=0) → full weight fetch occurs; latency is as in full mode.
- start_i pulsed while busy, and start_i held high → second start ignored mid-job. A held start_i launches a new job in the cycle after done_o.
- rst=0 during F_FETCH:
  - All outputs 0 next cycle, no done_o, weights_valid_o=0.
  - A subsequent mode_i=1 start performs a full fetch.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array load sequencer.
// Holds the FSM state encoding and counter-width helpers used by the top.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_DRAIN,
        F_FETCH,
        F_DRAIN,
        FLUSH,
        DONE
    } sa_state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SA_TAPS  = 9;
    localparam int SA_LANES = 3;
    localparam int SA_ROWS  = 2;

    localparam int TAP_IDX_W  = idx_w(SA_TAPS);
    localparam int FEAT_CNT_W = idx_w(SA_ROWS * SA_LANES);

endpackage

// File: rtl/sa_lane_skew.sv
// Triangular delay line: lane l sees a loaded row l+1 cycles after load_i.
// Data is zeroed alongside valid so idle lanes present 0.
module sa_lane_skew #(
    parameter int DATA_W = 8,
    parameter int LANES  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic [LANES-1:0][DATA_W-1:0] row_i,
    output logic [LANES*DATA_W-1:0]      data_o,
    output logic [LANES-1:0]             valid_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [l:0][DATA_W-1:0] d_q;
        logic [l:0]             v_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                d_q <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= load_i ? row_i[l] : '0;
                v_q[0] <= load_i;
                for (int s = 1; s <= l; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        assign data_o[l*DATA_W +: DATA_W] = d_q[l];
        assign valid_o[l]                 = v_q[l];
    end

endmodule

// File: rtl/sa_load_sequencer.sv
// Single-port RAM sequencer: preloads a weight bank, then streams feature rows
// into a per-lane skew pipe feeding the systolic array.
module sa_load_sequencer
    import sa_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int TAPS   = SA_TAPS,
    parameter int LANES  = SA_LANES,
    parameter int ROWS   = SA_ROWS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [ADDR_W-1:0]       weight_base_i,
    input  logic [ADDR_W-1:0]       feature_base_i,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic                    ram_rd_o,
    input  logic [DATA_W-1:0]       ram_q_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [TAPS*DATA_W-1:0]  weights_o,
    output logic                    weights_valid_o,
    output logic [LANES*DATA_W-1:0] feat_o,
    output logic [LANES-1:0]        feat_valid_o,
    output logic                    sa_en_o
);

    localparam int FEATS  = ROWS * LANES;
    localparam int CNT_W  = idx_w((TAPS > FEATS) ? TAPS : FEATS);
    localparam int TAP_W  = idx_w(TAPS);
    localparam int LANE_W = idx_w(LANES);

    localparam logic [CNT_W-1:0]  TAP_LAST   = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]  FEAT_LAST  = CNT_W'(FEATS - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(LANES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(LANES - 1);

    sa_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic                         accept, accept_full;

    logic [ADDR_W-1:0]            wbase_q, fbase_q, addr_hold_q, rd_addr;
    logic                         wvalid_q;
    logic                         rvld_q, rfeat_q;
    logic [TAP_W-1:0]             rtap_q;
    logic [LANE_W-1:0]            rlane_q;
    logic [TAPS-1:0][DATA_W-1:0]  weights_q;
    logic [LANES-1:0][DATA_W-1:0] stage_q, stage_d;
    logic                         row_load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        ram_rd_o    = 1'b0;
        accept      = 1'b0;
        accept_full = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept = 1'b1;
                    cnt_d  = '0;
                    lane_d = '0;
                    // Features-only needs a loaded bank; otherwise fall back to full.
                    if (mode_i && wvalid_q) begin
                        state_d = F_FETCH;
                    end else begin
                        state_d     = W_FETCH;
                        accept_full = 1'b1;
                    end
                end
            end
            W_FETCH: begin
                ram_rd_o = 1'b1;
                if (cnt_q == TAP_LAST) begin
                    cnt_d   = '0;
                    state_d = W_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_DRAIN: state_d = F_FETCH;
            F_FETCH: begin
                ram_rd_o = 1'b1;
                lane_d   = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
                if (cnt_q == FEAT_LAST) begin
                    cnt_d   = '0;
                    state_d = F_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            F_DRAIN: state_d = FLUSH;
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Feature count is linear r*LANES+l, so it doubles as the address offset.
    assign rd_addr    = ((state_q == W_FETCH) ? wbase_q : fbase_q) + ADDR_W'(cnt_q);
    assign ram_addr_o = ram_rd_o ? rd_addr : addr_hold_q;

    always_comb begin
        stage_d = stage_q;
        if (rvld_q && rfeat_q) stage_d[rlane_q] = ram_q_i;
    end

    assign row_load = rvld_q && rfeat_q && (rlane_q == LANE_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbase_q     <= '0;
            fbase_q     <= '0;
            addr_hold_q <= '0;
            wvalid_q    <= 1'b0;
            rvld_q      <= 1'b0;
            rfeat_q     <= 1'b0;
            rtap_q      <= '0;
            rlane_q     <= '0;
            weights_q   <= '0;
            stage_q     <= '0;
        end else begin
            if (accept) begin
                wbase_q <= weight_base_i;
                fbase_q <= feature_base_i;
            end
            if (accept_full)          wvalid_q <= 1'b0;
            else if (state_q == W_DRAIN) wvalid_q <= 1'b1;
            if (ram_rd_o) addr_hold_q <= rd_addr;
            // Tag travels with the read so the returning word knows its destination.
            rvld_q  <= ram_rd_o;
            rfeat_q <= (state_q == F_FETCH);
            rtap_q  <= cnt_q[TAP_W-1:0];
            rlane_q <= lane_q;
            if (rvld_q && !rfeat_q) weights_q[rtap_q] <= ram_q_i;
            stage_q <= stage_d;
        end
    end

    sa_lane_skew #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .load_i  (row_load),
        .row_i   (stage_d),
        .data_o  (feat_o),
        .valid_o (feat_valid_o)
    );

    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign weights_o       = weights_q;
    assign weights_valid_o = wvalid_q;
    assign sa_en_o         = |feat_valid_o;

endmodule
